// File: rtl/metadata_counters.sv
// HUD game-state counters (timer, lives, bombs, score, level) and game FSM.
// Optional METADATA_EXTRA_LIFE_EN: award one life per 1000-point score crossing.
module metadata_counters #(
  parameter int CLK_FREQ_HZ     = 31500000,
  parameter int TIMER_START_SEC = 180,
  parameter int LIVES_START     = 3,
  parameter int BOMBS_MAX       = 3,
  parameter int LEVEL_MAX       = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_game,
  input  logic        i_pause,
  input  logic        i_life_lost,
  input  logic        i_bomb_placed,
  input  logic        i_bomb_returned,
  input  logic        i_score_inc,
  input  logic [3:0]  i_score_amount,
  input  logic        i_level_done,
  output logic [11:0] o_timer_digits,
  output logic [15:0] o_score_digits,
  output logic [3:0]  o_lives,
  output logic [3:0]  o_bombs,
  output logic [3:0]  o_level,
  output logic        o_running,
  output logic        o_game_over,
  output logic        o_game_won,
  output logic        o_sec_tick
);

  // state  | meaning
  // IDLE   | after reset, counters cleared, waiting for start
  // RUN    | game in progress, events and timer active
  // OVER   | lives exhausted, everything frozen
  // WIN    | final level completed, everything frozen
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER, S_WIN} state_t;

  localparam int              PW         = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_TC   = PW'(CLK_FREQ_HZ - 1);
  localparam logic [11:0]     TIMER_BCD  = {4'(TIMER_START_SEC / 100),
                                            4'((TIMER_START_SEC / 10) % 10),
                                            4'(TIMER_START_SEC % 10)};
  localparam logic [3:0]      LIVES_INIT = 4'(LIVES_START);
  localparam logic [3:0]      BOMBS_INIT = 4'(BOMBS_MAX);
  localparam logic [3:0]      LEVEL_LAST = 4'(LEVEL_MAX);

  function automatic logic [11:0] bcd3_dec(input logic [11:0] v);
    logic [11:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Carry out of the thousands digit means the true sum exceeded 9999.
  function automatic logic [15:0] bcd4_add(input logic [15:0] v, input logic [3:0] amt);
    logic [15:0] r;
    logic [4:0]  s;
    logic        carry;
    r     = v;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, v[i*4 +: 4]} + {4'd0, carry};
      if (i == 0) s = s + {1'b0, amt};
      if (s > 5'd9) begin
        r[i*4 +: 4] = 4'(s - 5'd10);
        carry       = 1'b1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        carry       = 1'b0;
      end
    end
    if (carry) r = 16'h9999;
    return r;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [11:0]   r_timer;
  logic [15:0]   r_score;
  logic [3:0]    r_lives, r_bombs, r_level;
  logic          r_sec_tick, r_running, r_game_over, r_game_won;

  logic          w_in_run, w_presc_tc, w_expire, w_life_evt, w_level_evt, w_win;
  logic          w_extra, w_bomb_reload;
  logic [3:0]    w_amt, w_lives_nxt;
  logic [15:0]   w_score_sum;

  assign w_in_run      = (r_state == S_RUN);
  assign w_presc_tc    = w_in_run && !i_pause && (r_presc == PRESC_TC);
  assign w_expire      = w_presc_tc && (r_timer == 12'h001);
  assign w_level_evt   = w_in_run && i_level_done;
  assign w_win         = w_level_evt && (r_level == LEVEL_LAST);
  assign w_life_evt    = w_in_run && (i_life_lost || w_expire) && !i_level_done;
  assign w_bomb_reload = w_level_evt && !w_win;
  assign w_amt         = (i_score_amount > 4'd9) ? 4'd9 : i_score_amount;
  assign w_score_sum   = bcd4_add(r_score, w_amt);

`ifdef METADATA_EXTRA_LIFE_EN
  assign w_extra = w_in_run && i_score_inc && (w_score_sum[15:12] > r_score[15:12]) &&
                   (r_lives < 4'd9);
`else
  assign w_extra = 1'b0;
`endif

  always_comb begin
    w_lives_nxt = r_lives;
    if (w_life_evt && !w_extra && r_lives != 4'd0) begin
      w_lives_nxt = r_lives - 4'd1;
    end else if (w_extra && !w_life_evt) begin
      w_lives_nxt = r_lives + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start_game) begin
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN) begin
      if (w_win)                                   w_state_nxt = S_WIN;
      else if (w_life_evt && w_lives_nxt == 4'd0)  w_state_nxt = S_OVER;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
      r_game_won  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_running   <= (w_state_nxt == S_RUN);
      r_game_over <= (w_state_nxt == S_OVER);
      r_game_won  <= (w_state_nxt == S_WIN);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc    <= '0;
      r_timer    <= 12'h000;
      r_score    <= 16'h0000;
      r_lives    <= 4'd0;
      r_bombs    <= 4'd0;
      r_level    <= 4'd0;
      r_sec_tick <= 1'b0;
    end else if (i_start_game) begin
      r_presc    <= '0;
      r_timer    <= TIMER_BCD;
      r_score    <= 16'h0000;
      r_lives    <= LIVES_INIT;
      r_bombs    <= BOMBS_INIT;
      r_level    <= 4'd1;
      r_sec_tick <= 1'b0;
    end else if (w_in_run) begin
      r_sec_tick <= 1'b0;
      r_lives    <= w_lives_nxt;
      if (i_score_inc) r_score <= w_score_sum;

      // A winning levelDone freezes timer and prescaler where they are.
      if (w_level_evt) begin
        if (!w_win) begin
          r_level <= r_level + 4'd1;
          r_timer <= TIMER_BCD;
          r_presc <= '0;
        end
      end else if (w_life_evt) begin
        r_timer    <= TIMER_BCD;
        r_presc    <= '0;
        r_sec_tick <= w_expire;
      end else if (!i_pause) begin
        if (w_presc_tc) begin
          r_presc    <= '0;
          r_timer    <= bcd3_dec(r_timer);
          r_sec_tick <= 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end

      if (w_bomb_reload) begin
        r_bombs <= BOMBS_INIT;
      end else if (i_bomb_placed && !i_bomb_returned && r_bombs != 4'd0) begin
        r_bombs <= r_bombs - 4'd1;
      end else if (i_bomb_returned && !i_bomb_placed && r_bombs < BOMBS_INIT) begin
        r_bombs <= r_bombs + 4'd1;
      end
    end else begin
      r_sec_tick <= 1'b0;
    end
  end

  assign o_timer_digits = r_timer;
  assign o_score_digits = r_score;
  assign o_lives        = r_lives;
  assign o_bombs        = r_bombs;
  assign o_level        = r_level;
  assign o_running      = r_running;
  assign o_game_over    = r_game_over;
  assign o_game_won     = r_game_won;
  assign o_sec_tick     = r_sec_tick;

endmodule

// File: doc/metadata_counters.md
# metadata_counters

- Owns the HUD game-state values: countdown timer, lives, bombs available, score and level.
- Holds them in registered counters and drives the timer, lives, bombs, score and level digit drawers that feed the metadata mux.
- Event pulses from the game logic update the counters.
- It also flags game-over and win conditions back to the game controller.

## Interface
- CLK_FREQ_HZ, 31500000, clock cycles per timer second (prescaler terminal count + 1)
- TIMER_START_SEC, 180, timer reload value in seconds, 1..999
- LIVES_START, 3, lives loaded on game start, 1..9
- BOMBS_MAX, 3, bombs available on game start and upper bound, 1..9
- LEVEL_MAX, 3, final level, 1..9
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- startGame  in  1  pulse: load all counters, enter RUN
- pause  in  1  level: freezes timer and prescaler while high in RUN
- lifeLost  in  1  pulse: player died
- bombPlaced  in  1  pulse: bomb consumed
- bombReturned  in  1  pulse: bomb exploded, returned to stock
- scoreInc  in  1  pulse: add scoreAmount to score
- scoreAmount  in  4  points to add, 0..9 (values >9 treated as 9)
- levelDone  in  1  pulse: level exit reached
- timerDigits  out  12  timer as 3 BCD digits, hundreds in [11:8]
- scoreDigits  out  16  score as 4 BCD digits, thousands in [15:12]
- lives  out  4  binary lives count
- bombs  out  4  binary bombs available
- level  out  4  binary current level, 1-based
- running  out  1  high in RUN
- gameOver  out  1  high in OVER
- gameWon  out  1  high in WIN
- secTick  out  1  one-cycle pulse on each timer decrement

## Operation
- Reset is synchronous, active-high.
- FSM states: IDLE, RUN, OVER, WIN. Reset → IDLE.
- startGame is accepted in any state.
  - Loads timer = TIMER_START_SEC (BCD), lives = LIVES_START, bombs = BOMBS_MAX, score = 0000, level = 1, prescaler = 0.
  - Next state is RUN.
  - startGame has priority over every other input in the same cycle.
- In IDLE, OVER and WIN, all counters hold and all event pulses are ignored.
- Prescaler, RUN with pause low: counts 0..CLK_FREQ_HZ-1. At terminal count it wraps to 0, the timer decrements by 1 in BCD with borrow across digits, and secTick pulses.
- Timer expiry: the timer decrements from 001 to 000. Expiry is treated exactly as a lifeLost event, and the timer reloads to TIMER_START_SEC.
- Life loss: lives decrements. If the result is 0, the FSM goes to OVER. Lives never underflow.
- A life loss (lifeLost or timer expiry) also reloads the timer and clears the prescaler.
- Bombs:
  - bombPlaced decrements, but only if bombs > 0.
  - bombReturned increments, but only if bombs < BOMBS_MAX.
  - Both in the same cycle: no change.
- Score: scoreInc adds scoreAmount to the units digit. The BCD carry ripples through tens, hundreds and thousands. The sum saturates at 9999.
- levelDone:
  - If level == LEVEL_MAX, the FSM goes to WIN and counters hold.
  - Otherwise level increments, the timer reloads, the prescaler clears and bombs reload to BOMBS_MAX.
- Same-cycle priority in RUN:
  - levelDone wins over lifeLost and timer expiry. The life is not lost.
  - lifeLost together with timer expiry costs one life only.
  - Score and bomb events apply independently of the above in the same cycle.
- pause has no effect on event pulses; only the prescaler and timer freeze.

## Timing
- All outputs are registered.
- Reset values: timerDigits 12'h000, scoreDigits 16'h0000, lives 0, bombs 0, level 0, running 0, gameOver 0, gameWon 0, secTick 0.
- Latency: an input pulse sampled at edge N is reflected on the outputs after edge N (visible in cycle N+1). This includes FSM flags.
- secTick is high in the same cycle the new timerDigits value is visible.
- The first decrement after startGame occurs CLK_FREQ_HZ unpaused RUN cycles after startGame is sampled.
- Reset mid-game: all values clear on the next edge. Only a new startGame leaves IDLE.
- Pulses longer than one cycle are counted once per cycle high. Edge detection is the sender's responsibility.

## Configuration
- METADATA_EXTRA_LIFE_EN:
  - Defined: each time scoreDigits crosses a 1000 boundary (thousands digit increases, saturation excluded), lives increments, capped at 9. If this coincides with a life loss, the net lives change is 0.
  - Undefined: score never affects lives.

## Test plan
- CLK_FREQ_HZ=10, TIMER_START_SEC=3: reset, startGame → timer 003, lives 3, bombs 3, level 1, score 0000, running=1. After 10 cycles timer=002 and secTick pulses once.
- Timer 003, no events, 30 cycles → one life lost: lives 2, timer reloaded to 003. pause high for 25 cycles → timer unchanged.
- bombPlaced ×4 → bombs 0 (no underflow). Then bombPlaced+bombReturned in the same cycle → bombs 0. Then bombReturned ×5 → bombs 3.
- Score 0995, scoreInc with scoreAmount=7 → 1002. Score 9998, scoreAmount=9 → 9999.
  - With METADATA_EXTRA_LIFE_EN, the 0995→1002 step also gives lives +1.
- lives 1: lifeLost → lives 0, gameOver=1. Further pulses are ignored. startGame → RUN with reloaded values.
- LEVEL_MAX=2: levelDone+lifeLost in the same cycle → level 2, lives unchanged, bombs reloaded. Next levelDone → gameWon=1.
